// File: rtl/wb_vec_cmd_bridge.sv
// Wishbone classic slave that buffers management-SoC writes into a command stream
// for the vector core and returns vector-core results through a readable FIFO.
module wb_vec_cmd_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CMD_DEPTH = 4,
    parameter int          RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_data,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    output logic        irq
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RCW = RAW + 1;

    localparam logic [1:0] OFF_CMD    = 2'd0;
    localparam logic [1:0] OFF_RSP    = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    logic           wb_ack_q, wb_ack_d;
    logic [31:0]    wb_dat_q, wb_dat_d;

    logic [31:0]    cmd_mem_q [CMD_DEPTH];
    logic [31:0]    cmd_mem_d [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [CAW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;

    logic [31:0]    rsp_mem_q [RSP_DEPTH];
    logic [31:0]    rsp_mem_d [RSP_DEPTH];
    logic [RAW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [RAW-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [RCW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic        cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic        accept;
    logic [1:0]  off;
    logic        flush, clear;
    logic        cmd_wr, cmd_push, cmd_pop;
    logic        rsp_rd, rsp_push, rsp_pop;
    logic [31:0] status_word;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^wbs_adr_i[1:0];

    assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign rsp_full  = (rsp_cnt_q == RCW'(RSP_DEPTH));
    assign rsp_empty = (rsp_cnt_q == '0);

    // Both streams use valid/ready: a word transfers on any rising edge where
    // valid and ready are both high; valid never depends on ready.
    assign cmd_valid = !cmd_empty;
    assign cmd_data  = cmd_mem_q[cmd_rd_ptr_q];
    assign rsp_ready = !rsp_full;
    assign irq       = !rsp_empty | overflow_q | underflow_q;

    assign wbs_ack_o = wb_ack_q;
    assign wbs_dat_o = wb_dat_q;

    assign accept = wbs_cyc_i & wbs_stb_i & !wb_ack_q
                    & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off    = wbs_adr_i[3:2];

    assign flush  = accept & wbs_we_i & (off == OFF_CTRL) & wbs_dat_i[1];
    assign clear  = accept & wbs_we_i & (off == OFF_CTRL) & wbs_dat_i[0];

    // Full/empty are judged on pre-edge state, so a same-edge pop never rescues a write.
    assign cmd_wr   = accept & wbs_we_i & (off == OFF_CMD) & (wbs_sel_i == 4'hF);
    assign cmd_push = cmd_wr & !cmd_full;
    assign cmd_pop  = cmd_valid & cmd_ready & !flush;

    assign rsp_rd   = accept & !wbs_we_i & (off == OFF_RSP);
    assign rsp_pop  = rsp_rd & !rsp_empty;
    assign rsp_push = rsp_valid & rsp_ready & !flush;

    always_comb begin
        status_word        = '0;
        status_word[0]     = cmd_full;
        status_word[1]     = cmd_empty;
        status_word[2]     = rsp_full;
        status_word[3]     = rsp_empty;
        status_word[4]     = overflow_q;
        status_word[5]     = underflow_q;
        status_word[15:8]  = 8'(cmd_cnt_q);
        status_word[23:16] = 8'(rsp_cnt_q);
    end

    always_comb begin
        wb_ack_d = accept;
        wb_dat_d = '0;
        if (accept && !wbs_we_i) begin
            case (off)
                OFF_RSP:    wb_dat_d = rsp_empty ? 32'h0 : rsp_mem_q[rsp_rd_ptr_q];
                OFF_STATUS: wb_dat_d = status_word;
                default:    wb_dat_d = '0;
            endcase
        end
    end

    always_comb begin
        cmd_mem_d    = cmd_mem_q;
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        cmd_cnt_d    = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
        if (cmd_push) begin
            cmd_mem_d[cmd_wr_ptr_q] = wbs_dat_i;
            cmd_wr_ptr_d            = cmd_wr_ptr_q + CAW'(1);
        end
        if (cmd_pop) begin
            cmd_rd_ptr_d = cmd_rd_ptr_q + CAW'(1);
        end

        rsp_mem_d    = rsp_mem_q;
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        rsp_cnt_d    = rsp_cnt_q + RCW'(rsp_push) - RCW'(rsp_pop);
        if (rsp_push) begin
            rsp_mem_d[rsp_wr_ptr_q] = rsp_data;
            rsp_wr_ptr_d            = rsp_wr_ptr_q + RAW'(1);
        end
        if (rsp_pop) begin
            rsp_rd_ptr_d = rsp_rd_ptr_q + RAW'(1);
        end

        // Flush empties both queues; storage contents are left stale but unreachable.
        if (flush) begin
            cmd_wr_ptr_d = '0;
            cmd_rd_ptr_d = '0;
            cmd_cnt_d    = '0;
            rsp_wr_ptr_d = '0;
            rsp_rd_ptr_d = '0;
            rsp_cnt_d    = '0;
        end

        overflow_d  = overflow_q | (cmd_wr & cmd_full);
        underflow_d = underflow_q | (rsp_rd & rsp_empty);
        if (clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_q     <= 1'b0;
            wb_dat_q     <= '0;
            cmd_mem_q    <= '{default: '0};
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_cnt_q    <= '0;
            rsp_mem_q    <= '{default: '0};
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wb_ack_q     <= wb_ack_d;
            wb_dat_q     <= wb_dat_d;
            cmd_mem_q    <= cmd_mem_d;
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rsp_mem_q    <= rsp_mem_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_cnt_q    <= rsp_cnt_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end
endmodule

// File: tb/tb_wb_vec_cmd_bridge.sv
// Self-checking bench for wb_vec_cmd_bridge: directed scenarios plus a randomized
// run checked every cycle against a queue-based model of the register map.
module tb_wb_vec_cmd_bridge;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CMD = 32'h3000_0000;
    localparam logic [31:0] A_RSP = 32'h3000_0004;
    localparam logic [31:0] A_STS = 32'h3000_0008;
    localparam logic [31:0] A_CTL = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_vec_cmd_bridge #(.BASE_ADDR(BASE), .CMD_DEPTH(D), .RSP_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .irq(irq)
    );

    // Reference model: two word queues, two sticky flags and the expected bus outputs.
    logic [31:0] m_cmd_q[$];
    logic [31:0] m_rsp_q[$];
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_ack = 1'b0;
    logic [31:0] m_dat = '0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_cmd_q.size() == D);
        s[1]     = (m_cmd_q.size() == 0);
        s[2]     = (m_rsp_q.size() == D);
        s[3]     = (m_rsp_q.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_unf;
        s[15:8]  = 8'(m_cmd_q.size());
        s[23:16] = 8'(m_rsp_q.size());
        return s;
    endfunction

    always @(posedge clk) begin : model
        logic        acc, fl, cl;
        logic [1:0]  o;
        int          cs, rs;
        logic [31:0] st, nd;
        if (reset) begin
            m_cmd_q.delete();
            m_rsp_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_dat = '0;
        end else begin
            cs  = m_cmd_q.size();
            rs  = m_rsp_q.size();
            st  = m_status();
            nd  = '0;
            acc = wbs_cyc_i && wbs_stb_i && !m_ack && (wbs_adr_i[31:4] == BASE[31:4]);
            o   = wbs_adr_i[3:2];
            fl  = acc && wbs_we_i && (o == 2'd3) && wbs_dat_i[1];
            cl  = acc && wbs_we_i && (o == 2'd3) && wbs_dat_i[0];
            if (cs > 0 && cmd_ready) void'(m_cmd_q.pop_front());
            if (acc && wbs_we_i && o == 2'd0 && wbs_sel_i == 4'hF) begin
                if (cs == D) m_ovf = 1'b1;
                else m_cmd_q.push_back(wbs_dat_i);
            end
            if (acc && !wbs_we_i && o == 2'd1) begin
                if (rs == 0) m_unf = 1'b1;
                else nd = m_rsp_q.pop_front();
            end
            if (acc && !wbs_we_i && o == 2'd2) nd = st;
            if (rsp_valid && rs < D) m_rsp_q.push_back(rsp_data);
            if (fl) begin
                m_cmd_q.delete();
                m_rsp_q.delete();
            end
            if (cl) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            m_ack = acc;
            m_dat = nd;
        end
    end

    task automatic idle_inputs();
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 4'h0;
        wbs_adr_i = '0; wbs_dat_i = '0;
        cmd_ready = 0; rsp_valid = 0; rsp_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // One bus transfer; optionally pops the command FIFO / pushes a response on the accept edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic pop_cmd, input logic push_rsp,
                           input logic [31:0] rdat, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
        wbs_adr_i = adr; wbs_dat_i = dat;
        cmd_ready = pop_cmd; rsp_valid = push_rsp; rsp_data = rdat;
        lat = -1; rdata = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cmd_ready = 0; rsp_valid = 0;
            if (wbs_ack_o) begin
                lat = k;
                rdata = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, output int lat);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, 4'hF, 1'b0, 1'b0, '0, rd, lat);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata, output int lat);
        wb_xfer(1'b0, adr, '0, 4'hF, 1'b0, 1'b0, '0, rdata, lat);
    endtask

    task automatic test_reset();
        int lat;
        do_reset();
        n_cmp++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin n_err++;
            $display("FAIL reset_bus: got ack=%b dat=%h expected ack=0 dat=0", wbs_ack_o, wbs_dat_o); end
        n_cmp++; if (cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin n_err++;
            $display("FAIL reset_cmd: got valid=%b data=%h expected 0/0", cmd_valid, cmd_data); end
        n_cmp++; if (rsp_ready !== 1'b1 || irq !== 1'b0) begin n_err++;
            $display("FAIL reset_rsp_irq: got rsp_ready=%b irq=%b expected 1/0", rsp_ready, irq); end
        // Reset lands while an ack is pending: ack and stored word must vanish.
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = A_CMD; wbs_dat_i = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if (wbs_ack_o !== 1'b1 || cmd_valid !== 1'b1) begin n_err++;
            $display("FAIL pre_reset_write: got ack=%b valid=%b expected 1/1", wbs_ack_o, cmd_valid); end
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        n_cmp++; if (wbs_ack_o !== 1'b0 || cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin n_err++;
            $display("FAIL mid_reset: got ack=%b valid=%b data=%h expected 0/0/0", wbs_ack_o, cmd_valid, cmd_data); end
        lat = 0;
    endtask

    task automatic test_cmd_write();
        int lat; logic [31:0] rd;
        do_reset();
        wb_write(A_CMD, 32'hA5A5_0001, lat);
        n_cmp++; if (lat !== 1) begin n_err++;
            $display("FAIL cmd_ack_latency: got %0d expected 1", lat); end
        @(negedge clk);
        n_cmp++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin n_err++;
            $display("FAIL ack_single_cycle: got ack=%b dat=%h expected 0/0", wbs_ack_o, wbs_dat_o); end
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hA5A5_0001) begin n_err++;
            $display("FAIL cmd_head: got valid=%b data=%h expected 1/a5a50001", cmd_valid, cmd_data); end
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_0108) begin n_err++;
            $display("FAIL status_one_cmd: got %h expected 00000108", rd); end
        wb_read(A_CMD, rd, lat);
        n_cmp++; if (rd !== 32'h0 || lat !== 1) begin n_err++;
            $display("FAIL cmd_read_zero: got %h lat %0d expected 0 lat 1", rd, lat); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] rd;
        do_reset();
        for (int i = 1; i <= 4; i++) wb_write(A_CMD, 32'(i), lat);
        wb_write(A_CMD, 32'hDEAD_BEEF, lat);
        n_cmp++; if (lat !== 1) begin n_err++;
            $display("FAIL overflow_ack: got lat %0d expected 1", lat); end
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_0419 || irq !== 1'b1) begin n_err++;
            $display("FAIL overflow_status: got %h irq=%b expected 00000419 irq=1", rd, irq); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 32'(i)) begin n_err++;
                $display("FAIL drain_order: got valid=%b data=%h expected 1/%h", cmd_valid, cmd_data, 32'(i)); end
            cmd_ready = 1;
        end
        @(negedge clk);
        cmd_ready = 0;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++;
            $display("FAIL drained_empty: got valid=%b data=%h expected valid=0", cmd_valid, cmd_data); end
        wb_write(A_CTL, 32'h1, lat);
        n_cmp++; if (irq !== 1'b0) begin n_err++;
            $display("FAIL overflow_cleared_irq: got %b expected 0", irq); end
    endtask

    task automatic test_rsp();
        int lat; logic [31:0] rd;
        do_reset();
        @(negedge clk);
        rsp_valid = 1; rsp_data = 32'h11;
        n_cmp++; if (rsp_ready !== 1'b1) begin n_err++;
            $display("FAIL rsp_ready_0: got %b expected 1", rsp_ready); end
        @(negedge clk);
        rsp_data = 32'h22;
        n_cmp++; if (rsp_ready !== 1'b1) begin n_err++;
            $display("FAIL rsp_ready_1: got %b expected 1", rsp_ready); end
        @(negedge clk);
        rsp_valid = 0;
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0002_0002 || irq !== 1'b1) begin n_err++;
            $display("FAIL rsp_status: got %h irq=%b expected 00020002 irq=1", rd, irq); end
        wb_read(A_RSP, rd, lat);
        n_cmp++; if (rd !== 32'h11) begin n_err++;
            $display("FAIL rsp_read_0: got %h expected 00000011", rd); end
        wb_read(A_RSP, rd, lat);
        n_cmp++; if (rd !== 32'h22) begin n_err++;
            $display("FAIL rsp_read_1: got %h expected 00000022", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_err++;
            $display("FAIL rsp_irq_low: got %b expected 0", irq); end
    endtask

    task automatic test_underflow();
        int lat; logic [31:0] rd;
        wb_read(A_RSP, rd, lat);
        n_cmp++; if (rd !== 32'h0 || lat !== 1) begin n_err++;
            $display("FAIL underflow_read: got %h lat %0d expected 0 lat 1", rd, lat); end
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_002A || irq !== 1'b1) begin n_err++;
            $display("FAIL underflow_status: got %h irq=%b expected 0000002a irq=1", rd, irq); end
        wb_write(A_CTL, 32'h1, lat);
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_000A || irq !== 1'b0) begin n_err++;
            $display("FAIL clear_flags: got %h irq=%b expected 0000000a irq=0", rd, irq); end
    endtask

    task automatic test_full_pop_same_edge();
        int lat; logic [31:0] rd;
        do_reset();
        for (int i = 1; i <= 4; i++) wb_write(A_CMD, 32'(i), lat);
        wb_xfer(1'b1, A_CMD, 32'h0000_0BAD, 4'hF, 1'b1, 1'b0, '0, rd, lat);
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_0318) begin n_err++;
            $display("FAIL full_pop_status: got %h expected 00000318", rd); end
        n_cmp++; if (cmd_data !== 32'h2) begin n_err++;
            $display("FAIL full_pop_head: got %h expected 00000002", cmd_data); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd;
        do_reset();
        wb_write(A_CMD, 32'd100, lat);
        for (int i = 0; i < 10; i++) begin
            wb_xfer(1'b1, A_CMD, 32'(200 + i), 4'hF, 1'b1, 1'b0, '0, rd, lat);
            n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 32'(200 + i)) begin n_err++;
                $display("FAIL wrap_pair: got valid=%b data=%h expected 1/%h", cmd_valid, cmd_data, 32'(200 + i)); end
        end
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_0108) begin n_err++;
            $display("FAIL wrap_status: got %h expected 00000108", rd); end
    endtask

    task automatic test_flush_nomatch();
        int lat; logic [31:0] rd;
        do_reset();
        wb_write(A_CMD, 32'h1, lat);
        wb_write(A_CMD, 32'h2, lat);
        @(negedge clk);
        rsp_valid = 1; rsp_data = 32'h55;
        @(negedge clk);
        rsp_valid = 0;
        wb_xfer(1'b1, A_CTL, 32'h2, 4'h0, 1'b1, 1'b1, 32'h66, rd, lat);
        n_cmp++; if (cmd_valid !== 1'b0 || irq !== 1'b0 || rsp_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_outputs: got valid=%b irq=%b rsp_ready=%b expected 0/0/1", cmd_valid, irq, rsp_ready); end
        wb_read(A_STS, rd, lat);
        n_cmp++; if (rd !== 32'h0000_000A) begin n_err++;
            $display("FAIL flush_status: got %h expected 0000000a", rd); end
        wb_write(32'h3000_0010, 32'h77, lat);
        n_cmp++; if (lat !== -1 || cmd_valid !== 1'b0) begin n_err++;
            $display("FAIL nomatch_write: got lat %0d valid=%b expected no ack, valid=0", lat, cmd_valid); end
        wb_read(32'h3000_0018, rd, lat);
        n_cmp++; if (lat !== -1) begin n_err++;
            $display("FAIL nomatch_read: got lat %0d expected no ack", lat); end
    endtask

    task automatic test_random();
        logic busy; int held; int r;
        do_reset();
        busy = 0; held = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_cmp++; if (wbs_ack_o !== m_ack || wbs_dat_o !== m_dat) begin n_err++;
                $display("FAIL rand_bus c=%0d: got ack=%b dat=%h expected ack=%b dat=%h", c, wbs_ack_o, wbs_dat_o, m_ack, m_dat); end
            n_cmp++; if (cmd_valid !== (m_cmd_q.size() > 0)) begin n_err++;
                $display("FAIL rand_cmd_valid c=%0d: got %b expected %b", c, cmd_valid, m_cmd_q.size() > 0); end
            if (m_cmd_q.size() > 0) begin
                n_cmp++; if (cmd_data !== m_cmd_q[0]) begin n_err++;
                    $display("FAIL rand_cmd_data c=%0d: got %h expected %h", c, cmd_data, m_cmd_q[0]); end
            end
            n_cmp++; if (rsp_ready !== (m_rsp_q.size() < D) || irq !== (m_rsp_q.size() > 0 || m_ovf || m_unf)) begin n_err++;
                $display("FAIL rand_rsp_irq c=%0d: got rsp_ready=%b irq=%b expected %b/%b", c, rsp_ready, irq,
                         m_rsp_q.size() < D, m_rsp_q.size() > 0 || m_ovf || m_unf); end
            if (busy) begin
                held++;
                if (wbs_ack_o || held >= 3) begin
                    busy = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                busy = 1; held = 0;
                wbs_cyc_i = 1; wbs_stb_i = 1;
                wbs_sel_i = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                wbs_dat_i = $urandom;
                r = $urandom_range(0, 15);
                wbs_adr_i = BASE | 32'($urandom_range(0, 3));
                if (r <= 5)       begin wbs_we_i = 1; wbs_adr_i[3:2] = 2'd0; end
                else if (r <= 9)  begin wbs_we_i = 0; wbs_adr_i[3:2] = 2'd1; end
                else if (r <= 11) begin wbs_we_i = 0; wbs_adr_i[3:2] = 2'd2; end
                else if (r == 12) begin wbs_we_i = 1; wbs_adr_i[3:2] = 2'd3; wbs_dat_i = 32'($urandom_range(0, 3)); end
                else if (r == 13) begin wbs_we_i = 1; wbs_adr_i[3:2] = 2'($urandom_range(1, 2)); end
                else if (r == 14) begin wbs_we_i = 0; wbs_adr_i[3:2] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3; end
                else              begin wbs_we_i = $urandom_range(0, 1); wbs_adr_i = BASE + 32'h10 * 32'($urandom_range(1, 9)); end
            end
            cmd_ready = ($urandom_range(0, 3) == 0);
            rsp_valid = ($urandom_range(0, 1) == 0);
            rsp_data  = $urandom;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_cmd_write();
        test_overflow();
        test_rsp();
        test_underflow();
        test_full_pop_same_edge();
        test_back_to_back();
        test_flush_nomatch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
